// File: rtl/eeprom_cmd_seq.sv
`timescale 1ns/1ps
// Host-side command sequencer for eeprom_ctrl: builds the I2C control byte, runs the
// req/ack/busy handshake, reports read data or ack timeout, then waits out tWR after writes.
module eeprom_cmd_seq #(
    parameter logic [2:0] DEV_ADDR       = 3'b011,
    parameter int         REQ_CYCLES     = 3,
    parameter int         TWR_CYCLES     = 250000,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  ctrl_byte,
    output logic [31:0] data_in,
    output logic        req,
    input  logic        ack,
    input  logic [31:0] data_out,
    input  logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FREE,
        ISSUE,
        WAIT_ACK,
        RESP,
        WR_RECOVER
    } state_t;

    localparam logic [31:0] REQ_LOAD = 32'(REQ_CYCLES - 1);
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TWR_LOAD = 32'(TWR_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        is_rd, is_rd_nxt;
    logic [7:0]  ctrl_byte_nxt;
    logic [31:0] data_in_nxt;
    logic [31:0] rsp_rdata_nxt;
    logic        rsp_err_nxt;

    // Handshake outputs are registered from the next state so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_rd     <= 1'b0;
            cmd_ready <= 1'b0;
            req       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            data_in   <= '0;
            ctrl_byte <= {4'b1010, DEV_ADDR, 1'b0};
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            is_rd     <= is_rd_nxt;
            cmd_ready <= (state_nxt == IDLE);
            req       <= (state_nxt == ISSUE);
            rsp_valid <= (state_nxt == RESP);
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            data_in   <= data_in_nxt;
            ctrl_byte <= ctrl_byte_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        is_rd_nxt     = is_rd;
        ctrl_byte_nxt = ctrl_byte;
        data_in_nxt   = data_in;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    ctrl_byte_nxt = {4'b1010, DEV_ADDR, cmd_rd};
                    if (!cmd_rd) begin
                        data_in_nxt = cmd_wdata;
                    end
                    is_rd_nxt = cmd_rd;
                    state_nxt = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (!busy) begin
                    cnt_nxt   = REQ_LOAD;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == '0) begin
                    cnt_nxt   = TMO_LOAD;
                    state_nxt = WAIT_ACK;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            // A late ack on the very last timeout cycle still counts as success.
            WAIT_ACK: begin
                if (ack) begin
                    if (is_rd) begin
                        rsp_rdata_nxt = data_out;
                    end
                    rsp_err_nxt = 1'b0;
                    state_nxt   = RESP;
                end else if (cnt == '0) begin
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            // Recovery runs even after a failed write: the device may still be programming.
            RESP: begin
                if (is_rd) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = TWR_LOAD;
                    state_nxt = WR_RECOVER;
                end
            end
            WR_RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
`timescale 1ns/1ps
// Bench for eeprom_cmd_seq: the main thread plays both host and eeprom_ctrl, and checks
// every response against a word-level model of the EEPROM contents and the sequencer rules.
module tb_eeprom_cmd_seq;

    localparam int         TWR = 100;
    localparam int         TMO = 2000;
    localparam int         REQ = 3;
    localparam logic [2:0] DEV = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  ctrl_byte;
    logic [31:0] data_in;
    logic        req;
    logic        ack;
    logic [31:0] data_out;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem;
    logic [31:0] ref_data_in;
    logic [31:0] ref_rdata;
    logic [31:0] eep_mem;

    always #10 clk = ~clk;

    eeprom_cmd_seq #(
        .DEV_ADDR      (DEV),
        .REQ_CYCLES    (REQ),
        .TWR_CYCLES    (TWR),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rd   (cmd_rd),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .ctrl_byte(ctrl_byte),
        .data_in  (data_in),
        .req      (req),
        .ack      (ack),
        .data_out (data_out),
        .busy     (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One host command with the bench acting as eeprom_ctrl; always returns just after a negedge.
    task automatic applyStimulus(input bit rd, input logic [31:0] wdata, input int busy_hold,
                                 input bit mute, input bit b2b);
        int          k;
        int          n;
        int          lat;
        bit          quiet;
        bit          err;
        logic [7:0]  exp_ctrl;
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_wdata = wdata;
        if (busy_hold > 0) busy = 1'b1;
        k = 0;
        while (!cmd_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("accept_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        exp_ctrl  = {4'b1010, DEV, rd};
        if (!rd) ref_data_in = wdata;
        checkOutput("ctrl_byte", 32'(ctrl_byte), 32'(exp_ctrl));
        checkOutput("data_in", data_in, ref_data_in);
        checkOutput("ready_low_after_accept", 32'(cmd_ready), 32'd0);
        k = 1;
        if (k >= busy_hold) busy = 1'b0;
        while (!req && k < busy_hold + 10) begin
            @(negedge clk);
            k++;
            if (k >= busy_hold) busy = 1'b0;
        end
        checkOutput("req_rise_delay", 32'(k), 32'((busy_hold < 1 ? 1 : busy_hold) + 1));
        busy = 1'b1;
        n = 0;
        while (req && n < 10) begin
            n++;
            @(negedge clk);
        end
        checkOutput("req_width", 32'(n), 32'(REQ));
        if (!mute) begin
            lat   = $urandom_range(0, 5);
            quiet = 1'b1;
            repeat (lat) begin
                if (rsp_valid) quiet = 1'b0;
                data_out = $urandom;
                @(negedge clk);
            end
            checkOutput("no_early_rsp", 32'(quiet), 32'd1);
            ack  = 1'b1;
            busy = 1'b0;
            if (rd) begin
                data_out = eep_mem;
            end else begin
                eep_mem  = data_in;
                data_out = $urandom;
            end
            @(negedge clk);
            ack      = 1'b0;
            data_out = $urandom;
            err      = 1'b0;
            if (rd) ref_rdata = ref_mem;
            else    ref_mem   = wdata;
        end else begin
            k = 0;
            while (!rsp_valid && k < 2 * TMO) begin
                @(negedge clk);
                k++;
            end
            busy = 1'b0;
            checkOutput("timeout_delay", 32'(k), 32'(TMO));
            err       = 1'b1;
            ref_rdata = '0;
        end
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_err", 32'(rsp_err), 32'(err));
        checkOutput("rsp_rdata", rsp_rdata, ref_rdata);
        @(negedge clk);
        checkOutput("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        if (b2b) begin
            cmd_valid = 1'b1;
            cmd_rd    = 1'b1;
            cmd_wdata = $urandom;
        end
        k = 0;
        while (!cmd_ready && k < 3 * TWR) begin
            k++;
            @(negedge clk);
        end
        checkOutput("ready_gap", 32'(k), 32'(rd ? 0 : TWR));
        if (b2b) checkOutput("b2b_ctrl_hold", 32'(ctrl_byte), 32'(exp_ctrl));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int n;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_rd      = 1'b0;
        cmd_wdata   = '0;
        ack         = 1'b0;
        busy        = 1'b0;
        data_out    = '0;
        eep_mem     = 32'hDEAD_BEEF;
        ref_mem     = 32'hDEAD_BEEF;
        ref_data_in = '0;
        ref_rdata   = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_req", 32'(req), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_data_in", data_in, 32'd0);
        checkOutput("rst_ctrl_byte", 32'(ctrl_byte), 32'hA6);
        rst = 1'b0;
        #1;
        checkOutput("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_after_release", 32'(cmd_ready), 32'd1);

        $display("[TB] directed write then read back");
        applyStimulus(1'b0, 32'h1234_5678, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, $urandom, 0, 1'b0, 1'b0);

        $display("[TB] random commands");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), 1'b0, 1'b0);
        end

        $display("[TB] busy gating");
        applyStimulus(1'b0, $urandom, 50, 1'b0, 1'b0);
        applyStimulus(1'b1, $urandom, 7, 1'b0, 1'b0);

        $display("[TB] stray ack in idle");
        for (int i = 0; i < 3; i++) begin
            ack      = 1'b1;
            data_out = $urandom;
            @(negedge clk);
            ack = 1'b0;
            @(negedge clk);
            checkOutput("stray_ack_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("stray_ack_rdata", rsp_rdata, ref_rdata);
            checkOutput("stray_ack_ready", 32'(cmd_ready), 32'd1);
        end

        $display("[TB] back-to-back write then read");
        applyStimulus(1'b0, $urandom, 0, 1'b0, 1'b1);
        applyStimulus(1'b1, $urandom, 0, 1'b0, 1'b0);

        $display("[TB] ack timeouts");
        applyStimulus(1'b1, $urandom, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, $urandom, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, $urandom, 0, 1'b0, 1'b0);

        $display("[TB] reset during ack wait");
        cmd_valid = 1'b1;
        cmd_rd    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!req && k < 20) begin
            @(negedge clk);
            k++;
        end
        while (req && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("abort_reached_wait_ack", 32'(k < 40), 32'd1);
        repeat (10) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("abort_req", 32'(req), 32'd0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_ready", 32'(cmd_ready), 32'd0);
        checkOutput("abort_ctrl_byte", 32'(ctrl_byte), 32'hA6);
        checkOutput("abort_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("abort_data_in", data_in, 32'd0);
        ref_data_in = '0;
        ref_rdata   = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready_after_release", 32'(cmd_ready), 32'd1);
        n = 0;
        repeat (TMO + 50) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        checkOutput("abort_no_stale_rsp", 32'(n), 32'd0);

        applyStimulus(1'b1, $urandom, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, $urandom, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, $urandom, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
